// File: rtl/sha1_core_wb.sv
// sha1_core_wb: Wishbone register front-end around an iterative SHA-1 compression engine.
// Latency: ack one cycle after a transfer is seen; done 80/ROUNDS_PER_CYCLE+1 cycles after START ack.
// Backpressure: none, each transfer is acked once; SHA1_CORE_WB_IRQ_EN adds an irq enable bit in CTRL.
module sha1_core_wb #(
  parameter logic [31:0] BASE_ADDRESS     = 32'h30000024,
  parameter int          ROUNDS_PER_CYCLE = 1
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        done,
  output logic        irq
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 10 &&
      ROUNDS_PER_CYCLE != 16 && ROUNDS_PER_CYCLE != 20) begin : g_bad_rounds
    $error("sha1_core_wb: ROUNDS_PER_CYCLE must be 1, 2, 4, 5, 8, 10, 16 or 20");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_t;

  localparam logic [31:0] ID_VALUE   = 32'h53484132;
  localparam logic [31:0] BAD_READ   = 32'h0FFFFFEA;
  localparam logic [31:0] H0_INIT    = 32'h67452301;
  localparam logic [31:0] H1_INIT    = 32'hEFCDAB89;
  localparam logic [31:0] H2_INIT    = 32'h98BADCFE;
  localparam logic [31:0] H3_INIT    = 32'h10325476;
  localparam logic [31:0] H4_INIT    = 32'hC3D2E1F0;
  localparam logic [6:0]  RPC        = 7'(ROUNDS_PER_CYCLE);
  localparam logic [6:0]  LAST_ROUND = 7'(80 - ROUNDS_PER_CYCLE);

  state_t      state_q, state_d;
  logic        ack_q, ack_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic [31:0] dat_q, dat_d;
  logic [6:0]  round_q, round_d;
  logic [4:0]  msg_cnt_q, msg_cnt_d;
  logic [8:0]  blk_cnt_q, blk_cnt_d;
  logic [31:0] a_q, b_q, c_q, d_q, e_q, a_d, b_d, c_d, d_d, e_d;
  logic [31:0] h_q [5];
  logic [31:0] h_d [5];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
`ifdef SHA1_CORE_WB_IRQ_EN
  logic        irq_en_q, irq_en_d;
`endif

  // Address decode: word-spaced registers in a 32-byte window above BASE_ADDRESS.
  logic [31:0] off, status, rd_val;
  logic [2:0]  idx;
  logic        mapped, acc, busy, wr_full, ctrl_wr, msg_wr;
  assign off     = wbs_adr_i - BASE_ADDRESS;
  assign mapped  = (off[31:5] == 27'd0) && (off[1:0] == 2'd0);
  assign idx     = off[4:2];
  assign acc     = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign busy    = (state_q != S_IDLE);
  assign wr_full = acc & wbs_we_i & (wbs_sel_i == 4'hF) & mapped;
  assign ctrl_wr = wr_full & (idx == 3'd1);
  assign msg_wr  = wr_full & (idx == 3'd2);

`ifdef SHA1_CORE_WB_IRQ_EN
  assign status = {7'(ROUNDS_PER_CYCLE), blk_cnt_q, msg_cnt_q, round_q, irq_en_q, err_q, done_q, busy};
  assign irq_d  = irq_en_q & (done_q | err_q);
`else
  assign status = {8'(ROUNDS_PER_CYCLE), blk_cnt_q, msg_cnt_q, round_q, err_q, done_q, busy};
  assign irq_d  = 1'b0;
`endif

  // Read mux; digest words are the committed chaining value, untouched until FINAL.
  always_comb begin
    rd_val = BAD_READ;
    if (mapped) begin
      case (idx)
        3'd0:    rd_val = ID_VALUE;
        3'd1:    rd_val = status;
        3'd3:    rd_val = h_q[0];
        3'd4:    rd_val = h_q[1];
        3'd5:    rd_val = h_q[2];
        3'd6:    rd_val = h_q[3];
        3'd7:    rd_val = h_q[4];
        default: rd_val = BAD_READ;
      endcase
    end
  end

  // ROUNDS_PER_CYCLE unrolled rounds; the schedule shifts so w[0] is always the current W[t].
  logic [31:0] ra, rb, rc, rd, re;
  logic [31:0] rw [16];
  always_comb begin
    logic [31:0] f, k, tmp, nw;
    logic [6:0]  t;
    f = 32'd0; k = 32'd0; tmp = 32'd0; nw = 32'd0; t = 7'd0;
    ra = a_q; rb = b_q; rc = c_q; rd = d_q; re = e_q;
    rw = w_q;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      t = round_q + 7'(r);
      if (t < 7'd20) begin
        f = (rb & rc) | (~rb & rd);          k = 32'h5A827999;
      end else if (t < 7'd40) begin
        f = rb ^ rc ^ rd;                    k = 32'h6ED9EBA1;
      end else if (t < 7'd60) begin
        f = (rb & rc) | (rb & rd) | (rc & rd); k = 32'h8F1BBCDC;
      end else begin
        f = rb ^ rc ^ rd;                    k = 32'hCA62C1D6;
      end
      tmp = {ra[26:0], ra[31:27]} + f + re + k + rw[0];
      nw  = rw[13] ^ rw[8] ^ rw[2] ^ rw[0];
      re = rd; rd = rc; rc = {rb[1:0], rb[31:2]}; rb = ra; ra = tmp;
      for (int i = 0; i < 15; i++) rw[i] = rw[i + 1];
      rw[15] = {nw[30:0], nw[31]};
    end
  end

  // Next-state: bus handshake, FSM, register writes. Writes act after the FSM step so INIT precedes START.
  always_comb begin
    state_d = state_q;   ack_d = acc;         dat_d = dat_q;
    done_d = done_q;     err_d = err_q;       round_d = round_q;
    msg_cnt_d = msg_cnt_q; blk_cnt_d = blk_cnt_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; e_d = e_q;
    h_d = h_q; w_d = w_q;
`ifdef SHA1_CORE_WB_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    if (acc && !wbs_we_i) dat_d = rd_val;
    case (state_q)
      S_RUN: begin
        a_d = ra; b_d = rb; c_d = rc; d_d = rd; e_d = re;
        w_d = rw;
        round_d = round_q + RPC;
        if (round_q == LAST_ROUND) state_d = S_FINAL;
      end
      S_FINAL: begin
        h_d[0] = h_q[0] + a_q; h_d[1] = h_q[1] + b_q; h_d[2] = h_q[2] + c_q;
        h_d[3] = h_q[3] + d_q; h_d[4] = h_q[4] + e_q;
        blk_cnt_d = blk_cnt_q + 9'd1;
        msg_cnt_d = 5'd0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: ;
    endcase
    if (ctrl_wr) begin
      if (wbs_dat_i[2]) begin
        done_d = 1'b0; err_d = 1'b0;
      end
`ifdef SHA1_CORE_WB_IRQ_EN
      irq_en_d = wbs_dat_i[3];
`endif
      if (busy) begin
        if (wbs_dat_i[0] | wbs_dat_i[1]) err_d = 1'b1;
      end else begin
        if (wbs_dat_i[1]) begin
          h_d[0] = H0_INIT; h_d[1] = H1_INIT; h_d[2] = H2_INIT; h_d[3] = H3_INIT; h_d[4] = H4_INIT;
          blk_cnt_d = 9'd0;
          done_d    = 1'b0;
        end
        if (wbs_dat_i[0]) begin
          if (msg_cnt_q == 5'd16) begin
            state_d = S_RUN; round_d = 7'd0; done_d = 1'b0;
            a_d = h_d[0]; b_d = h_d[1]; c_d = h_d[2]; d_d = h_d[3]; e_d = h_d[4];
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
    if (msg_wr) begin
      if (busy || msg_cnt_q == 5'd16) begin
        err_d = 1'b1;
      end else begin
        w_d[msg_cnt_q[3:0]] = wbs_dat_i;
        msg_cnt_d = msg_cnt_q + 5'd1;
      end
    end
  end

  // Control and chaining state, cleared by reset at any time including mid-run.
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  ack_q <= 1'b0;  dat_q <= 32'd0;
      done_q <= 1'b0;     err_q <= 1'b0;  irq_q <= 1'b0;
      round_q <= 7'd0;    msg_cnt_q <= 5'd0; blk_cnt_q <= 9'd0;
      a_q <= 32'd0; b_q <= 32'd0; c_q <= 32'd0; d_q <= 32'd0; e_q <= 32'd0;
      h_q[0] <= H0_INIT; h_q[1] <= H1_INIT; h_q[2] <= H2_INIT; h_q[3] <= H3_INIT; h_q[4] <= H4_INIT;
`ifdef SHA1_CORE_WB_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  ack_q <= ack_d;  dat_q <= dat_d;
      done_q <= done_d;    err_q <= err_d;  irq_q <= irq_d;
      round_q <= round_d;  msg_cnt_q <= msg_cnt_d; blk_cnt_q <= blk_cnt_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; e_q <= e_d;
      h_q <= h_d;
`ifdef SHA1_CORE_WB_IRQ_EN
      irq_en_q <= irq_en_d;
`endif
    end
  end

  // Message/schedule buffer has no reset; it is always refilled before START is accepted.
  always_ff @(posedge wb_clk_i) begin
    w_q <= w_d;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign done      = done_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_sha1_core_wb.sv
// Testbench for sha1_core_wb: directed vectors plus randomized multi-block hashing
// against a plain SHA-1 reference model and a transaction-level register model.
module tb_sha1_core_wb;
  localparam logic [31:0] BASE = 32'h30000024;
  localparam int RPC = 1;
  localparam int LAT = 80 / RPC + 1;
  localparam logic [31:0] A_CTRL = BASE + 32'h04;
  localparam logic [31:0] A_MSG  = BASE + 32'h08;
  localparam logic [31:0] A_DIG0 = BASE + 32'h0C;
`ifdef SHA1_CORE_WB_IRQ_EN
  localparam logic [31:0] ST_MASK = ~32'h000007F0;
`else
  localparam logic [31:0] ST_MASK = ~32'h000003F8;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] dat_i = 32'd0, adr = 32'd0;
  logic ack, done, irq;
  logic [31:0] dat_o;

  sha1_core_wb #(.BASE_ADDRESS(BASE), .ROUNDS_PER_CYCLE(RPC)) dut (
    .wb_clk_i(clk), .reset(reset), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack),
    .wbs_dat_o(dat_o), .done(done), .irq(irq));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc_cnt = 0, last_acc = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference state
  logic [31:0] m_h [5];
  logic [31:0] m_new [5];
  logic [31:0] m_w [16];
  int m_msg, m_blk, m_start;
  bit m_err, m_done, m_pend, m_en, m_irq_prev;
  logic [31:0] abc_ref [5] = '{32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d};
  logic [31:0] two_ref [5] = '{32'h84983e44, 32'h1c3bd26e, 32'hbaae4aa1, 32'hf95129e5, 32'he54670f1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h[0] = 32'h67452301; m_h[1] = 32'hEFCDAB89; m_h[2] = 32'h98BADCFE;
    m_h[3] = 32'h10325476; m_h[4] = 32'hC3D2E1F0;
    m_msg = 0; m_blk = 0; m_err = 0; m_done = 0; m_pend = 0; m_en = 0; m_irq_prev = 0;
  endtask

  // Textbook SHA-1 compression of m_w onto m_h, result in m_new.
  task automatic compress_model();
    logic [31:0] x [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) x[i] = m_w[i];
    for (int i = 16; i < 80; i++) begin
      t = x[i-3] ^ x[i-8] ^ x[i-14] ^ x[i-16];
      x[i] = {t[30:0], t[31]};
    end
    a = m_h[0]; b = m_h[1]; c = m_h[2]; d = m_h[3]; e = m_h[4];
    for (int i = 0; i < 80; i++) begin
      case (i / 20)
        0: begin f = (b & c) | (~b & d); k = 32'h5A827999; end
        1: begin f = b ^ c ^ d; k = 32'h6ED9EBA1; end
        2: begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        default: begin f = b ^ c ^ d; k = 32'hCA62C1D6; end
      endcase
      t = {a[26:0], a[31:27]} + f + e + k + x[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    m_new[0] = m_h[0] + a; m_new[1] = m_h[1] + b; m_new[2] = m_h[2] + c;
    m_new[3] = m_h[3] + d; m_new[4] = m_h[4] + e;
  endtask

  function automatic logic [31:0] status_model();
`ifdef SHA1_CORE_WB_IRQ_EN
    return {7'(RPC), 9'(m_blk), 5'(m_msg), 7'd0, m_en, m_err, m_done, m_pend};
`else
    return {8'(RPC), 9'(m_blk), 5'(m_msg), 7'd0, m_err, m_done, m_pend};
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a == BASE) return 32'h53484132;
    if (a == A_CTRL) return status_model();
    for (int i = 0; i < 5; i++) if (a == A_DIG0 + 32'(4 * i)) return m_h[i];
    return 32'h0FFFFFEA;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (s != 4'hF) return;
    if (a == A_CTRL) begin
      if (d[2]) begin m_done = 0; m_err = 0; end
`ifdef SHA1_CORE_WB_IRQ_EN
      m_en = d[3];
`endif
      if (m_pend) begin
        if (d[0] | d[1]) m_err = 1;
      end else begin
        if (d[1]) begin
          m_h[0] = 32'h67452301; m_h[1] = 32'hEFCDAB89; m_h[2] = 32'h98BADCFE;
          m_h[3] = 32'h10325476; m_h[4] = 32'hC3D2E1F0;
          m_blk = 0; m_done = 0;
        end
        if (d[0]) begin
          if (m_msg == 16) begin
            compress_model();
            m_pend = 1; m_start = cyc_cnt; m_done = 0;
          end else m_err = 1;
        end
      end
    end else if (a == A_MSG) begin
      if (m_pend || m_msg == 16) m_err = 1;
      else begin m_w[m_msg] = d; m_msg++; end
    end
  endtask

  // One Wishbone transfer; reads are checked against the model, writes update it.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    logic [31:0] e;
    @(negedge clk);
    stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk); #1;
    last_acc = cyc_cnt;
    chk("ack_rise", 32'(ack), 32'd1);
    r = dat_o;
    stb = 0; cyc = 0; we = 0;
    if (!w) begin
      e = exp_read(a);
      if (a == A_CTRL) chk("status", r & ST_MASK, e & ST_MASK);
      else chk("read", r, e);
    end else model_write(a, d, s);
    @(posedge clk); #1;
    chk("ack_fall", 32'(ack), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, 4'hF, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bus(1'b0, a, 32'd0, 4'h0, r);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < LAT + 40 && m_pend; i++) begin
      @(posedge clk); #4;
    end
    if (m_pend) chk("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic load_abc();
    wr(A_MSG, 32'h61626380);
    for (int i = 0; i < 14; i++) wr(A_MSG, 32'd0);
    wr(A_MSG, 32'h00000018);
  endtask

  task automatic check_digest(input string nm, input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3, input logic [31:0] r4);
    logic [31:0] r;
    logic [31:0] refv [5];
    refv[0] = r0; refv[1] = r1; refv[2] = r2; refv[3] = r3; refv[4] = r4;
    for (int i = 0; i < 5; i++) begin
      rd(A_DIG0 + 32'(4 * i), r);
      chk(nm, r, refv[i]);
      chk({nm, "_model"}, m_h[i], refv[i]);
    end
  endtask

  // Per-cycle compare of done/irq (and reset values) against the model.
  always @(posedge clk) begin
    #3;
    if (reset) begin
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      m_irq_prev = 0;
    end else begin
      if (m_pend && (cyc_cnt - m_start >= LAT)) begin
        for (int i = 0; i < 5; i++) m_h[i] = m_new[i];
        m_blk = (m_blk + 1) % 512; m_msg = 0; m_done = 1; m_pend = 0;
      end
      chk("done", 32'(done), 32'(m_done));
      chk("irq", 32'(irq), 32'(m_irq_prev));
`ifdef SHA1_CORE_WB_IRQ_EN
      m_irq_prev = (m_done | m_err) & m_en;
`else
      m_irq_prev = 0;
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;

    // Reset-state reads
    rd(BASE, r);                 chk("id", r, 32'h53484132);
    rd(BASE + 32'h1C, r);        chk("dig4_reset", r, 32'hC3D2E1F0);
    rd(BASE + 32'h20, r);        chk("unmapped", r, 32'h0FFFFFEA);
    rd(A_MSG, r);
    rd(A_CTRL, r);

    // "abc" with latency measurement
    wr(A_CTRL, 32'h2);
    load_abc();
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) break;
      @(posedge clk); #2;
    end
    chk("latency", 32'(cyc_cnt - last_acc), 32'(LAT));
    wait_idle();
    check_digest("abc", abc_ref[0], abc_ref[1], abc_ref[2], abc_ref[3], abc_ref[4]);
    rd(A_CTRL, r);
    chk("abc_blk", 32'(r[23:15]), 32'd1);
    wr(A_CTRL, 32'h4);

    // Two-block message, no INIT between blocks
    wr(A_CTRL, 32'h2);
    for (int i = 0; i < 14; i++) wr(A_MSG, {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)});
    wr(A_MSG, 32'h80000000);
    wr(A_MSG, 32'd0);
    wr(A_CTRL, 32'h1);
    wait_idle();
    for (int i = 0; i < 15; i++) wr(A_MSG, 32'd0);
    wr(A_MSG, 32'h000001C0);
    wr(A_CTRL, 32'h1);
    wait_idle();
    check_digest("two_blk", two_ref[0], two_ref[1], two_ref[2], two_ref[3], two_ref[4]);
    rd(A_CTRL, r);
    chk("two_blk_cnt", 32'(r[23:15]), 32'd2);

    // Errors: early START, 17th write, partial selects
    wr(A_CTRL, 32'h6);
    wr(A_MSG, 32'h61626380);
    for (int i = 0; i < 4; i++) wr(A_MSG, 32'd0);
    wr(A_CTRL, 32'h1);
    rd(A_CTRL, r);
    chk("early_start_err", 32'(r[2:0]), 32'b100);
    wr(A_CTRL, 32'h4);
    for (int i = 0; i < 10; i++) wr(A_MSG, 32'd0);
    bus(1'b1, A_MSG, 32'hDEADBEEF, 4'h7, r);
    wr(A_MSG, 32'h00000018);
    wr(A_MSG, $urandom);
    rd(A_CTRL, r);
    bus(1'b1, A_CTRL, 32'h1, 4'hE, r);
    wr(A_CTRL, 32'h1);
    // Disturbances while running must not change the result
    wr(A_MSG, $urandom);
    wr(A_CTRL, 32'h3);
    rd(A_CTRL, r);
    chk("busy_during_run", 32'(r[0]), 32'd1);
    rd(A_DIG0, r);
    wait_idle();
    check_digest("abc_err", abc_ref[0], abc_ref[1], abc_ref[2], abc_ref[3], abc_ref[4]);
    rd(A_CTRL, r);

    // Reset mid-run, then rerun
    wr(A_CTRL, 32'h6);
    load_abc();
    wr(A_CTRL, 32'h1);
    repeat (38) @(posedge clk);
    #1; reset = 1; model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    rd(A_CTRL, r);
    rd(BASE + 32'h0C, r);        chk("h0_after_rst", r, 32'h67452301);
    load_abc();
    wr(A_CTRL, 32'h1);
    wait_idle();
    check_digest("abc_rerun", abc_ref[0], abc_ref[1], abc_ref[2], abc_ref[3], abc_ref[4]);

`ifdef SHA1_CORE_WB_IRQ_EN
    wr(A_CTRL, 32'hE);
    load_abc();
    wr(A_CTRL, 32'h9);
    wait_idle();
    repeat (2) @(posedge clk);
    chk("irq_high", 32'(irq), 32'd1);
    wr(A_CTRL, 32'hC);
    chk("irq_clr", 32'(irq), 32'd0);
    wr(A_CTRL, 32'h0);
`endif

    // Randomized multi-block hashing with nuisance transfers
    for (int it = 0; it < 6; it++) begin
      int nb;
      if ($urandom_range(0, 1) == 1) wr(A_CTRL, 32'h2);
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1) wr(BASE + 32'h20 + 32'(4 * $urandom_range(0, 3)), $urandom);
        if ($urandom_range(0, 1) == 1) bus(1'b1, A_MSG, $urandom, 4'(($urandom_range(0, 14))), r);
        if ($urandom_range(0, 1) == 1) rd(BASE + 32'h20, r);
        for (int i = 0; i < 16; i++) wr(A_MSG, $urandom);
        wr(A_CTRL, 32'h1);
        if ($urandom_range(0, 1) == 1) begin
          rd(A_CTRL, r);
          wr(A_MSG, $urandom);
          rd(A_DIG0 + 32'(4 * $urandom_range(0, 4)), r);
        end
        wait_idle();
      end
      for (int i = 0; i < 5; i++) rd(A_DIG0 + 32'(4 * i), r);
      rd(A_CTRL, r);
      wr(A_CTRL, 32'h4);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
